// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// regfile_param : parametrised 2R/1W register file with bypass, zero register
//                 and a sequential bulk-clear engine. Rev 1.0
// ============================================================================
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int OUT_IDX  = 30
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] rout,
  input  logic              ClrReq,
  output logic              ClrBusy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              clr_busy;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  logic              wr_is_zero;
  logic              we_eff;

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  // Clear FSM: state register
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Clear FSM: next state; the pointer wrap back to 0 coincides with the exit
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (ClrReq) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == PTR_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    clr_busy = (state_q == ST_CLEAR);
  end

  assign ClrBusy = clr_busy;

  always_comb begin
    wr_is_zero = (ZERO_REG != 0) && (WriteReg == '0);
    we_eff     = RegWrite && !clr_busy && !wr_is_zero;
  end

  // External writes are dropped, not queued, while the clear engine owns the array
  always_comb begin
    regs_d = regs_q;
    if (clr_busy) begin
      regs_d[clr_ptr_q] = '0;
    end else if (we_eff) begin
      regs_d[WriteReg] = WriteData;
    end
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rd_addr[0] = ReadReg1;
  assign rd_addr[1] = ReadReg2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
      end else if ((BYPASS != 0) && we_eff && (WriteReg == rd_addr[p])) begin
        rd_data[p] = WriteData;
      end else begin
        rd_data[p] = regs_q[rd_addr[p]];
      end
    end
  end

  assign ReadData1 = rd_data[0];
  assign ReadData2 = rd_data[1];
  assign rout      = regs_q[OUT_IDX];

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
// tb_regfile_param : scoreboard bench for regfile_param (default parameters).
//                    Rev 1.0
// ============================================================================
module tb_regfile_param;

  logic        Clk;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] rout;
  logic        ClrReq;
  logic        ClrBusy;

  int n_cmp = 0;
  int n_err = 0;
  int busy_len;

  string       tag_q [$];
  logic [31:0] exp_q [$];

  regfile_param #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .ZERO_REG(1),
    .BYPASS  (1),
    .OUT_IDX (30)
  ) u_dut (
    .Clk      (Clk),
    .rst      (rst),
    .RegWrite (RegWrite),
    .WriteReg (WriteReg),
    .WriteData(WriteData),
    .ReadReg1 (ReadReg1),
    .ReadReg2 (ReadReg2),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2),
    .rout     (rout),
    .ClrReq   (ClrReq),
    .ClrBusy  (ClrBusy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] pat(input int i);
    return {16'hC0DE, 8'(i), 8'h5A};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      check_val("sb_underflow", obs, 32'hxxxx_xxxx);
    end else begin
      check_val(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic fill();
    for (int i = 1; i < 32; i++) begin
      tick();
      RegWrite  = 1'b1;
      WriteReg  = 5'(i);
      WriteData = pat(i);
    end
    tick();
    RegWrite = 1'b0;
  endtask

  // Reads every register on both ports; only index 'special' may hold sval
  task automatic sweep(input string tag, input int special, input logic [31:0] sval);
    for (int i = 0; i < 32; i++) begin
      tick();
      RegWrite = 1'b0;
      ClrReq   = 1'b0;
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(31 - i);
      sb_push($sformatf("%s_rd1_r%0d", tag, i), (i == special) ? sval : 32'h0);
      sb_push($sformatf("%s_rd2_r%0d", tag, 31 - i), ((31 - i) == special) ? sval : 32'h0);
      @(negedge Clk);
      sb_pop(ReadData1);
      sb_pop(ReadData2);
    end
    sb_push({tag, "_rout"}, (special == 30) ? sval : 32'h0);
    sb_pop(rout);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 200; k++) begin
      @(negedge Clk);
      if (!ClrBusy) break;
    end
    sb_push(tag, 32'h0);
    sb_pop({31'b0, ClrBusy});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    RegWrite  = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    ReadReg1  = '0;
    ReadReg2  = '0;
    ClrReq    = 1'b0;
    repeat (2) @(posedge Clk);
    tick();
    rst = 1'b1;

    // Populate storage, then assert reset asynchronously mid-cycle
    tick(); RegWrite = 1'b1; WriteReg = 5'd5;  WriteData = 32'h0000_0055;
    tick(); WriteReg = 5'd30; WriteData = 32'h3030_3030;
    tick(); RegWrite = 1'b0; ReadReg1 = 5'd5; ReadReg2 = 5'd30;
    sb_push("pre_rst_rd1", 32'h0000_0055);
    sb_push("pre_rst_rout", 32'h3030_3030);
    @(negedge Clk);
    sb_pop(ReadData1);
    sb_pop(rout);
    #2; rst = 1'b0; #1;
    sb_push("rst_rd1", 32'h0);
    sb_push("rst_rd2", 32'h0);
    sb_push("rst_rout", 32'h0);
    sb_push("rst_busy", 32'h0);
    sb_pop(ReadData1);
    sb_pop(ReadData2);
    sb_pop(rout);
    sb_pop({31'b0, ClrBusy});
    tick();
    tick(); rst = 1'b1; ReadReg1 = 5'd5;
    sb_push("post_rst_r5", 32'h0);
    @(negedge Clk);
    sb_pop(ReadData1);

    // Same-cycle bypass, then stored read
    tick(); RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'hDEAD_BEEF; ReadReg1 = 5'd7; ReadReg2 = 5'd8;
    sb_push("byp_rd1", 32'hDEAD_BEEF);
    sb_push("byp_rd2_nomatch", 32'h0);
    @(negedge Clk);
    sb_pop(ReadData1);
    sb_pop(ReadData2);
    tick(); RegWrite = 1'b0; ReadReg2 = 5'd7;
    sb_push("stored_rd2_r7", 32'hDEAD_BEEF);
    @(negedge Clk);
    sb_pop(ReadData2);

    // Zero register: no bypass, no storage
    tick(); RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h1234_5678; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    sb_push("zero_byp_rd1", 32'h0);
    sb_push("zero_byp_rd2", 32'h0);
    @(negedge Clk);
    sb_pop(ReadData1);
    sb_pop(ReadData2);
    tick(); RegWrite = 1'b0;
    sb_push("zero_later_rd1", 32'h0);
    @(negedge Clk);
    sb_pop(ReadData1);

    // rout has no bypass
    tick(); RegWrite = 1'b1; WriteReg = 5'd30; WriteData = 32'hA5A5_A5A5;
    sb_push("rout_same_cycle", 32'h0);
    @(negedge Clk);
    sb_pop(rout);
    tick(); RegWrite = 1'b0;
    sb_push("rout_next_cycle", 32'hA5A5_A5A5);
    @(negedge Clk);
    sb_pop(rout);

    // Bulk clear with a dropped write, a repeated request and an immediate write after
    fill();
    ClrReq = 1'b1; ReadReg1 = 5'd3;
    sb_push("clr_c0_rd1_r3", pat(3));
    sb_push("clr_c0_busy", 32'h0);
    @(negedge Clk);
    sb_pop(ReadData1);
    sb_pop({31'b0, ClrBusy});
    busy_len = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      RegWrite = 1'b0;
      ClrReq   = 1'b0;
      if (k == 2) begin
        RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h1; ReadReg1 = 5'd3; ReadReg2 = 5'd20;
        sb_push("clr_c2_rd1_r3_nobyp", pat(3));
        sb_push("clr_c2_rd2_r20", pat(20));
      end
      if (k == 5) ClrReq = 1'b1;
      if (k == 10) begin
        ReadReg1 = 5'd3; ReadReg2 = 5'd20;
        sb_push("clr_c10_rd1_r3", 32'h0);
        sb_push("clr_c10_rd2_r20", pat(20));
      end
      if (k == 33) begin
        RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h0000_0099; ReadReg1 = 5'd9;
        sb_push("post_clr_byp_r9", 32'h0000_0099);
      end
      @(negedge Clk);
      if (k == 2 || k == 10) begin
        sb_pop(ReadData1);
        sb_pop(ReadData2);
      end
      if (k == 33) sb_pop(ReadData1);
      if (!ClrBusy) break;
      busy_len++;
    end
    sb_push("clr_busy_len", 32'd32);
    sb_pop(32'(busy_len));
    sweep("after_clr", 9, 32'h0000_0099);

    // Reset in the middle of a clear
    fill();
    ClrReq = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      ClrReq = 1'b0;
    end
    tick();
    ReadReg1 = 5'd25; ReadReg2 = 5'd31;
    sb_push("midclr_busy_before_rst", 32'h1);
    sb_pop({31'b0, ClrBusy});
    #1; rst = 1'b0; #1;
    sb_push("midclr_rst_busy", 32'h0);
    sb_push("midclr_rst_rd1_r25", 32'h0);
    sb_push("midclr_rst_rd2_r31", 32'h0);
    sb_push("midclr_rst_rout", 32'h0);
    @(negedge Clk);
    sb_pop({31'b0, ClrBusy});
    sb_pop(ReadData1);
    sb_pop(ReadData2);
    sb_pop(rout);
    tick();
    tick(); rst = 1'b1;
    sweep("after_midclr_rst", -1, 32'h0);
    sb_push("after_midclr_rst_busy", 32'h0);
    sb_pop({31'b0, ClrBusy});

    // Clear request and write in the same idle cycle
    tick(); ClrReq = 1'b1; RegWrite = 1'b1; WriteReg = 5'd4; WriteData = 32'h0000_00FF; ReadReg1 = 5'd4;
    sb_push("simul_c0_byp_r4", 32'h0000_00FF);
    @(negedge Clk);
    sb_pop(ReadData1);
    tick(); ClrReq = 1'b0; RegWrite = 1'b0;
    sb_push("simul_c1_r4", 32'h0000_00FF);
    sb_push("simul_c1_busy", 32'h1);
    @(negedge Clk);
    sb_pop(ReadData1);
    sb_pop({31'b0, ClrBusy});
    wait_idle("simul_clr_done");
    tick(); ReadReg1 = 5'd4;
    sb_push("simul_final_r4", 32'h0);
    @(negedge Clk);
    sb_pop(ReadData1);
    sweep("after_simul", -1, 32'h0);

    check_val("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
